// File: rtl/time_setter_if.sv
// time_setter_if: button, live-time and set-side signals between the clock counters and the time setter
interface time_setter_if;
   logic       btn_mode;
   logic       btn_inc;
   logic [4:0] cur_hour;
   logic [5:0] cur_minute;
   logic [4:0] set_hour;
   logic [5:0] set_minute;
   logic       set;
   logic       editing;
   logic       edit_field;
   modport master (
      output btn_mode, btn_inc, cur_hour, cur_minute,
      input  set_hour, set_minute, set, editing, edit_field
   );
   modport slave (
      input  btn_mode, btn_inc, cur_hour, cur_minute,
      output set_hour, set_minute, set, editing, edit_field
   );
endinterface

// File: rtl/time_setter.sv
// time_setter: hour/minute edit sequence with auto-repeat, timeout and a committed set strobe
module time_setter #(
   parameter int SET_PULSE     = 2,
   parameter int TIMEOUT       = 1000,
   parameter int REPEAT_DELAY  = 50,
   parameter int REPEAT_PERIOD = 10
) (
   input  logic         clk,
   input  logic         rst,
   time_setter_if.slave bus
);
   localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam int TW   = $clog2(TIMEOUT + 1);
   localparam int PW   = $clog2(SET_PULSE + 1);
   typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, COMMIT} state_t;
   state_t        state_q;
   logic          mode_q, inc_q, rpt_q, set_q, editing_q, field_q;
   logic [RW-1:0] rep_cnt_q;
   logic [TW-1:0] idle_cnt_q;
   logic [PW-1:0] pulse_cnt_q;
   logic [4:0]    hour_q, hour_d;
   logic [5:0]    minute_q, minute_d;
   logic          mode_press, inc_press, auto_step, in_edit, step;
   // Button edges, auto-repeat firing and wrapped increment values
   always_comb begin
      mode_press = bus.btn_mode & ~mode_q;
      inc_press  = bus.btn_inc & ~inc_q;
      auto_step  = bus.btn_inc && (rpt_q ? rep_cnt_q == RW'(REPEAT_PERIOD) : rep_cnt_q == RW'(REPEAT_DELAY));
      in_edit    = state_q == EDIT_H || state_q == EDIT_M;
      step       = in_edit && (inc_press || auto_step);
      hour_d     = hour_q == 5'd23 ? 5'd0 : hour_q + 5'd1;
      minute_d   = minute_q == 6'd59 ? 6'd0 : minute_q + 6'd1;
   end
   // Edit FSM; mode beats inc, the strobe starts one cycle after entering COMMIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         inc_q       <= 1'b0;
         rpt_q       <= 1'b0;
         set_q       <= 1'b0;
         editing_q   <= 1'b0;
         field_q     <= 1'b0;
         rep_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         pulse_cnt_q <= '0;
         hour_q      <= '0;
         minute_q    <= '0;
      end else begin
         mode_q <= bus.btn_mode;
         inc_q  <= bus.btn_inc;
         if (!bus.btn_inc || !in_edit) begin
            rep_cnt_q <= '0;
            rpt_q     <= 1'b0;
         end else if (auto_step) begin
            rep_cnt_q <= RW'(1);
            rpt_q     <= 1'b1;
         end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
         end
         case (state_q)
            IDLE: if (mode_press) begin
               hour_q     <= bus.cur_hour > 5'd23 ? 5'd0 : bus.cur_hour;
               minute_q   <= bus.cur_minute > 6'd59 ? 6'd0 : bus.cur_minute;
               state_q    <= EDIT_H;
               editing_q  <= 1'b1;
               field_q    <= 1'b0;
               idle_cnt_q <= '0;
            end
            EDIT_H, EDIT_M: if (mode_press) begin
               state_q     <= state_q == EDIT_H ? EDIT_M : COMMIT;
               editing_q   <= state_q == EDIT_H;
               field_q     <= state_q == EDIT_H;
               idle_cnt_q  <= '0;
               rep_cnt_q   <= '0;
               rpt_q       <= 1'b0;
               pulse_cnt_q <= '0;
            end else if (step) begin
               if (state_q == EDIT_H) hour_q <= hour_d;
               else minute_q <= minute_d;
               idle_cnt_q <= '0;
            end else if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
               state_q    <= IDLE;
               editing_q  <= 1'b0;
               field_q    <= 1'b0;
               idle_cnt_q <= '0;
            end else begin
               idle_cnt_q <= idle_cnt_q + 1'b1;
            end
            COMMIT: if (pulse_cnt_q == PW'(SET_PULSE)) begin
               set_q       <= 1'b0;
               state_q     <= IDLE;
               pulse_cnt_q <= '0;
            end else begin
               set_q       <= 1'b1;
               pulse_cnt_q <= pulse_cnt_q + 1'b1;
            end
         endcase
      end
   end
   assign bus.set        = set_q;
   assign bus.set_hour   = hour_q;
   assign bus.set_minute = minute_q;
   assign bus.editing    = editing_q;
   assign bus.edit_field = field_q;
endmodule

// File: doc/time_setter.md
Name: time_setter

Overview:
- Drives the set side of the hour and minute counters: set_hour, set_minute and the set strobe.
- Takes two synchronized, debounced push-buttons (mode, inc) and the live time.
- Runs an edit sequence: hour, then minute, then commit.
- Emits one set strobe that loads the edited time into the counters.

Parameters:
- SET_PULSE, 2: cycles the set strobe stays high on commit (>=1).
- TIMEOUT, 1000: idle cycles in an edit state before the edit is abandoned without set.
- REPEAT_DELAY, 50: cycles inc must be held before auto-repeat starts.
- REPEAT_PERIOD, 10: cycles between auto-repeat increments.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_mode  in  1  mode button level; already synchronized and debounced.
- btn_inc  in  1  increment button level; already synchronized and debounced.
- cur_hour  in  5  live hour 0..23 from the hour counter.
- cur_minute  in  6  live minute 0..59 from the minute counter.
- set_hour  out  5  hour value to load.
- set_minute  out  6  minute value to load.
- set  out  1  load strobe to the counters, active high; registered output.
- editing  out  1  high in EDIT_H and EDIT_M.
- edit_field  out  1  0 = hour being edited, 1 = minute being edited; 0 outside edit states.

Behaviour:
- Reset: state IDLE; set, set_hour, set_minute, editing, edit_field all 0; all counters and the button history registers 0.
- Edge detect: mode_press = btn_mode & ~btn_mode_q; inc_press = btn_inc & ~btn_inc_q. The *_q registers sample the buttons every cycle.
- States: IDLE, EDIT_H, EDIT_M, COMMIT.
- IDLE, on mode_press: set_hour <= cur_hour, or 0 if cur_hour > 23; set_minute <= cur_minute, or 0 if cur_minute > 59; go to EDIT_H. inc is ignored in IDLE.
- EDIT_H:
  - inc step: set_hour <= (set_hour == 23) ? 0 : set_hour + 1.
  - mode_press: go to EDIT_M.
- EDIT_M:
  - inc step: set_minute <= (set_minute == 59) ? 0 : set_minute + 1.
  - mode_press: go to COMMIT.
- Inc step (EDIT_H or EDIT_M) fires on:
  - inc_press, or
  - auto-repeat: btn_inc held continuously for REPEAT_DELAY cycles after its press, then every REPEAT_PERIOD cycles while held.
  - Releasing btn_inc clears the repeat counter. Entering a new edit state also clears it.
- Simultaneous mode_press and inc step: mode wins; no increment that cycle.
- Timeout:
  - An idle counter clears on any mode_press or inc step and on entry to an edit state.
  - When it reaches TIMEOUT in EDIT_H or EDIT_M: go to IDLE, set never asserted. set_hour/set_minute keep their values but are don't-care.
- COMMIT:
  - set is high for exactly SET_PULSE consecutive cycles, starting the cycle after the COMMIT transition edge; then go to IDLE and set <= 0.
  - Buttons are ignored in COMMIT.
  - set_hour/set_minute are frozen from entry to COMMIT until the next IDLE mode_press. They are therefore stable at least one cycle before set rises, which the counters' asynchronous set requires.
- set is never high outside COMMIT. Exactly one strobe per completed edit.
- Reset mid-edit or mid-COMMIT: immediate return to reset values; set drops asynchronously and no further strobe follows.
- Holding btn_mode produces a single press. A new press needs a release first.

Test Plan:
- Reset, then cur_hour=10, cur_minute=30, mode pressed -> editing=1, edit_field=0, set_hour=10, set_minute=30, set=0.
- From hour 22: 3 inc presses, mode, 2 inc presses, mode -> set_hour=1, set_minute=32; set high exactly 2 cycles; state IDLE; values held after.
- Minute at 58 in EDIT_M, btn_inc held 50+2*10 cycles -> increments 59, 0, 1; final set_minute=1, no carry into set_hour.
- Enter edit, no buttons for 1000 cycles -> editing=0, set never asserted; next mode press recaptures live time.
- mode and inc pressed on the same edge in EDIT_H -> advance to EDIT_M, set_hour unchanged. Then rst pulse mid-COMMIT -> set=0 immediately, all outputs 0.
- cur_hour=27, cur_minute=63 at capture -> set_hour=0, set_minute=0.
